// File: rtl/matvec_mul.sv
// Pipelined signed matrix-vector multiplier y = K * x: one registered multiply
// stage followed by a registered binary adder tree per row, all rows in parallel.

module matvec_row #(
  parameter int C   = 3,
  parameter int W_X = 8,
  parameter int W_K = 8,
  parameter int W_Y = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic [C-1:0][W_K-1:0]   k_row,
  input  logic [C-1:0][W_X-1:0]   x,
  output logic [W_Y-1:0]          y_row
);
  localparam int L   = $clog2(C);
  localparam int W_P = W_X + W_K;

  // Number of live operands at tree level l (level 0 = products).
  function automatic int lvl_cnt(input int l);
    return (C + (1 << l) - 1) >> l;
  endfunction

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int NC = lvl_cnt(l);
    logic signed [W_Y-1:0] r_node [NC];

    if (l == 0) begin : g_mul
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < NC; j++) r_node[j] <= '0;
        end else if (cen) begin
          for (int j = 0; j < NC; j++)
            r_node[j] <= W_Y'(W_P'($signed(k_row[j])) * W_P'($signed(x[j])));
        end
      end
    end else begin : g_add
      localparam int NP = lvl_cnt(l - 1);
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < NC; j++) r_node[j] <= '0;
        end else if (cen) begin
          for (int j = 0; j < NP / 2; j++)
            r_node[j] <= g_lvl[l-1].r_node[2*j] + g_lvl[l-1].r_node[2*j+1];
          // Odd operand count: the last one rides through this level unchanged.
          if (NP % 2 == 1)
            r_node[NC-1] <= g_lvl[l-1].r_node[NP-1];
        end
      end
    end
  end

  assign y_row = g_lvl[L].r_node[0];
endmodule

module matvec_mul #(
  parameter int R   = 3,
  parameter int C   = 3,
  parameter int W_X = 8,
  parameter int W_K = 8,
  localparam int W_Y = W_X + W_K + $clog2(C)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cen,
  input  logic [R-1:0][C-1:0][W_K-1:0]  k,
  input  logic [C-1:0][W_X-1:0]         x,
  output logic [R-1:0][W_Y-1:0]         y
);
  for (genvar r = 0; r < R; r++) begin : g_row
    matvec_row #(.C(C), .W_X(W_X), .W_K(W_K), .W_Y(W_Y)) u_row (
      .clk   (clk),
      .rst   (rst),
      .cen   (cen),
      .k_row (k[r]),
      .x     (x),
      .y_row (y[r])
    );
  end
endmodule

// File: tb/tb_matvec_mul.sv
// Bench for matvec_mul: four configurations driven from one shared stimulus,
// each checked every cycle against an integer dot-product model with latency.

module tb_matvec_mul;
  logic clk = 1'b0;
  logic rst, cen;
  always #5 clk = ~clk;

  int kk [4][5];
  int xx [5];

  logic [2:0][2:0][7:0] k_d; logic [2:0][7:0] x_d; logic [2:0][17:0] y_d;
  logic [0:0][0:0][7:0] k_a; logic [0:0][7:0] x_a; logic [0:0][15:0] y_a;
  logic [1:0][3:0][7:0] k_b; logic [3:0][7:0] x_b; logic [1:0][17:0] y_b;
  logic [3:0][4:0][7:0] k_c; logic [4:0][7:0] x_c; logic [3:0][18:0] y_c;

  always_comb begin
    k_d = '0; x_d = '0; k_a = '0; x_a = '0;
    k_b = '0; x_b = '0; k_c = '0; x_c = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        if (r < 3 && c < 3) k_d[r][c] = 8'(kk[r][c]);
        if (r < 1 && c < 1) k_a[r][c] = 8'(kk[r][c]);
        if (r < 2 && c < 4) k_b[r][c] = 8'(kk[r][c]);
        k_c[r][c] = 8'(kk[r][c]);
      end
    for (int c = 0; c < 5; c++) begin
      if (c < 3) x_d[c] = 8'(xx[c]);
      if (c < 1) x_a[c] = 8'(xx[c]);
      if (c < 4) x_b[c] = 8'(xx[c]);
      x_c[c] = 8'(xx[c]);
    end
  end

  matvec_mul u_dut_d (.clk(clk), .rst(rst), .cen(cen), .k(k_d), .x(x_d), .y(y_d));
  matvec_mul #(.R(1), .C(1)) u_dut_a (.clk(clk), .rst(rst), .cen(cen), .k(k_a), .x(x_a), .y(y_a));
  matvec_mul #(.R(2), .C(4)) u_dut_b (.clk(clk), .rst(rst), .cen(cen), .k(k_b), .x(x_b), .y(y_b));
  matvec_mul #(.R(4), .C(5)) u_dut_c (.clk(clk), .rst(rst), .cen(cen), .k(k_c), .x(x_c), .y(y_c));

  // Config table: rows, columns, expected latency.
  int RS [4] = '{3, 1, 2, 4};
  int CS [4] = '{3, 1, 4, 5};
  int LS [4] = '{3, 1, 3, 4};

  int res [4][2048][4];  // model result of the inputs taken at enabled edge e
  int n;                 // enabled edges since last reset
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int get_y(input int g, input int r);
    int v;
    v = 0;
    case (g)
      0: v = int'($signed(y_d[r]));
      1: v = int'($signed(y_a[r]));
      2: v = int'($signed(y_b[r]));
      3: v = int'($signed(y_c[r]));
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic int exp_y(input int g, input int r);
    if (n < LS[g]) return 0;
    return res[g][n - LS[g] + 1][r];
  endfunction

  task automatic check_all();
    for (int g = 0; g < 4; g++)
      for (int r = 0; r < RS[g]; r++)
        chk($sformatf("cfg%0d n%0d y[%0d]", g, n, r), get_y(g, r), exp_y(g, r));
  endtask

  task automatic tick();
    int s;
    @(posedge clk);
    if (rst) n = 0;
    else if (cen) begin
      n++;
      for (int g = 0; g < 4; g++)
        for (int r = 0; r < RS[g]; r++) begin
          s = 0;
          for (int c = 0; c < CS[g]; c++) s += kk[r][c] * xx[c];
          res[g][n][r] = s;
        end
    end
    #1 check_all();
  endtask

  task automatic clear_in();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) kk[r][c] = 0;
    for (int c = 0; c < 5; c++) xx[c] = 0;
  endtask

  task automatic set_t1();
    clear_in();
    kk[2][2] = 1; kk[2][1] = 2; kk[2][0] = 3;
    kk[1][2] = 4; kk[1][1] = 5; kk[1][0] = 6;
    kk[0][2] = 7; kk[0][1] = 8; kk[0][0] = 9;
    xx[2] = 1; xx[1] = 2; xx[0] = 3;
  endtask

  task automatic chk3(input string tag, input int e2, input int e1, input int e0);
    chk({tag, " y2"}, get_y(0, 2), e2);
    chk({tag, " y1"}, get_y(0, 1), e1);
    chk({tag, " y0"}, get_y(0, 0), e0);
  endtask

  task automatic fill(input int kv, input int xv);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) kk[r][c] = kv;
    for (int c = 0; c < 5; c++) xx[c] = xv;
  endtask

  initial begin
    n = 0; rst = 1'b1; cen = 1'b0;
    clear_in();
    #1 check_all();
    tick();
    rst = 1'b0;

    // Directed product, latency 3 on the default config
    set_t1(); cen = 1'b1;
    tick(); tick();
    chk3("t1 early", 0, 0, 0);
    tick();
    chk3("t1", 14, 32, 50);

    // Signed extremes
    fill(-128, -128);
    repeat (4) tick();
    chk3("t2 neg", 49152, 49152, 49152);
    chk("t2 neg c5", get_y(3, 0), 81920);
    fill(-128, 127);
    repeat (4) tick();
    chk3("t2 mix", -48768, -48768, -48768);

    // Back-to-back throughput
    set_t1(); xx[2] = 1; xx[1] = 0; xx[0] = 0;
    tick();
    xx[2] = 0; xx[0] = 1;
    tick();
    xx[0] = 0;
    tick();
    chk3("t3 a", 1, 4, 7);
    tick();
    chk3("t3 b", 3, 6, 9);

    // Clock-enable hold mid-flight with changing inputs
    set_t1();
    tick(); tick();
    cen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 5; c++) xx[c] = int'($urandom_range(0, 255)) - 128;
      tick();
    end
    cen = 1'b1;
    tick();
    chk3("t4", 14, 32, 50);

    // Async reset while results are in flight; reset beats cen at an edge
    set_t1();
    tick(); tick();
    #2 rst = 1'b1; n = 0;
    #1 check_all();
    chk3("t5 async", 0, 0, 0);
    tick();
    #2 rst = 1'b0;
    clear_in(); set_t1(); xx[2] = 1; xx[1] = 0; xx[0] = 0;
    tick(); tick();
    chk3("t5 no stale", 0, 0, 0);
    tick();
    chk3("t5 post", 1, 4, 7);

    // Randomized sweep over all configs with random enable
    for (int i = 0; i < 400; i++) begin
      cen = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        fill(($urandom_range(0, 1) != 0) ? -128 : 127, ($urandom_range(0, 1) != 0) ? -128 : 127);
      end else begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 5; c++) kk[r][c] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < 5; c++) xx[c] = int'($urandom_range(0, 255)) - 128;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
